// File: rtl/cu_pkg.sv
// Shared constants for the multicycle control unit: opcodes, ALU encodings
// and the step-counter state type.
package cu_pkg;

   localparam int OPCODE_W = 3;
   localparam int ALU_OP_W = 2;

   localparam logic [OPCODE_W-1:0] MV   = 3'b000;
   localparam logic [OPCODE_W-1:0] MVI  = 3'b001;
   localparam logic [OPCODE_W-1:0] ADD  = 3'b010;
   localparam logic [OPCODE_W-1:0] SUB  = 3'b011;
   localparam logic [OPCODE_W-1:0] AND_ = 3'b100;
   localparam logic [OPCODE_W-1:0] MVNZ = 3'b101;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   // Opcodes that go through A/G and therefore take the full four steps.
   function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
      return (op == ADD) || (op == SUB) || (op == AND_);
   endfunction

   function automatic logic [ALU_OP_W-1:0] alu_encode(input logic [OPCODE_W-1:0] op);
      logic [ALU_OP_W-1:0] enc;
      case (op)
         SUB:     enc = ALU_SUB;
         AND_:    enc = ALU_AND;
         default: enc = ALU_ADD;
      endcase
      return enc;
   endfunction

endpackage

// File: rtl/cu_reg_decode.sv
// Binary register index plus enable to a one-hot strobe vector.
module cu_reg_decode #(
   parameter int  NUM_REGS = 8,
   localparam int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic [SEL_W-1:0]    idx,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (idx == SEL_W'(i))) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cu_seq_ctrl.sv
// Step-counter control unit for the bus-based multicycle processor.
// Define CU_MVNZ_EN to execute opcode 101 as a conditional move; otherwise it is illegal.
module cu_seq_ctrl
   import cu_pkg::*;
#(
   parameter int  NUM_REGS          = 8,
   localparam int REG_SEL_W         = $clog2(NUM_REGS),
   localparam int INSTRUCTION_WIDTH = 3 + 2*REG_SEL_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         run,
   input  logic [INSTRUCTION_WIDTH-1:0] ir,
   input  logic                         g_nz,
   output logic [NUM_REGS-1:0]          reg_out,
   output logic [NUM_REGS-1:0]          reg_in,
   output logic                         din_out,
   output logic                         g_out,
   output logic                         ir_in,
   output logic                         a_in,
   output logic                         g_in,
   output logic [1:0]                   alu_op,
   output logic                         done,
   output logic                         illegal,
   output logic [1:0]                   step
);

   state_t state_q;
   state_t state_d;

   logic [OPCODE_W-1:0]  op;
   logic [REG_SEL_W-1:0] dest_idx;
   logic [REG_SEL_W-1:0] src_idx;
   logic [REG_SEL_W-1:0] out_idx;
   logic                 out_en;
   logic                 in_en;

   assign op       = ir[INSTRUCTION_WIDTH-1 -: OPCODE_W];
   assign dest_idx = ir[2*REG_SEL_W-1 -: REG_SEL_W];
   assign src_idx  = ir[REG_SEL_W-1:0];

`ifndef CU_MVNZ_EN
   logic unused_g_nz;
   assign unused_g_nz = g_nz;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= T0;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs are forced quiet whenever rst is high, so an aborted instruction
   // issues nothing in the cycle reset is asserted.
   always_comb begin
      state_d = state_q;
      out_idx = src_idx;
      out_en  = 1'b0;
      in_en   = 1'b0;
      din_out = 1'b0;
      g_out   = 1'b0;
      ir_in   = 1'b0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      alu_op  = ALU_ADD;
      done    = 1'b0;
      illegal = 1'b0;

      case (state_q)
         T0: begin
            if (run) begin
               ir_in   = 1'b1;
               din_out = 1'b1;
               state_d = T1;
            end
         end
         T1: begin
            state_d = T0;
            case (op)
               MV: begin
                  out_en = 1'b1;
                  in_en  = 1'b1;
                  done   = 1'b1;
               end
               MVI: begin
                  din_out = 1'b1;
                  in_en   = 1'b1;
                  done    = 1'b1;
               end
               ADD, SUB, AND_: begin
                  out_idx = dest_idx;
                  out_en  = 1'b1;
                  a_in    = 1'b1;
                  state_d = T2;
               end
`ifdef CU_MVNZ_EN
               MVNZ: begin
                  out_en = 1'b1;
                  in_en  = g_nz;
                  done   = 1'b1;
               end
`endif
               default: begin
                  done    = 1'b1;
                  illegal = 1'b1;
               end
            endcase
         end
         T2: begin
            out_en  = 1'b1;
            g_in    = 1'b1;
            alu_op  = is_alu_op(op) ? alu_encode(op) : ALU_ADD;
            state_d = T3;
         end
         T3: begin
            g_out   = 1'b1;
            in_en   = 1'b1;
            done    = 1'b1;
            state_d = T0;
         end
         default: begin
            state_d = T0;
         end
      endcase

      if (rst) begin
         out_en  = 1'b0;
         in_en   = 1'b0;
         din_out = 1'b0;
         g_out   = 1'b0;
         ir_in   = 1'b0;
         a_in    = 1'b0;
         g_in    = 1'b0;
         alu_op  = ALU_ADD;
         done    = 1'b0;
         illegal = 1'b0;
      end
   end

   assign step = rst ? 2'b00 : state_q;

   cu_reg_decode #(.NUM_REGS(NUM_REGS)) u_out_decode (
      .idx    (out_idx),
      .en     (out_en),
      .onehot (reg_out)
   );

   cu_reg_decode #(.NUM_REGS(NUM_REGS)) u_in_decode (
      .idx    (dest_idx),
      .en     (in_en),
      .onehot (reg_in)
   );

endmodule
